// File: rtl/esp_host_if.sv
// Polled CPU register block for the ESP32 command link: STATUS/DATA words
// in front of a 9-bit TX FIFO and an 8-bit RX FIFO.
module esp_host_if #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  output logic [8:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [8:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [DEPTH_LOG2:0]   tx_cnt_reg, rx_cnt_reg;
  logic                  rx_ovf_reg, tx_ovf_reg;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic status_wr, flush;
  logic tx_pop, tx_push, tx_drop;
  logic rx_pop, rx_push, rx_drop;
  logic [31:0] status_word;
  logic unused_wrdata;

  assign tx_empty = (tx_cnt_reg == '0);
  assign rx_empty = (rx_cnt_reg == '0);
  assign tx_full  = (tx_cnt_reg == FULL_CNT);
  assign rx_full  = (rx_cnt_reg == FULL_CNT);

  assign status_wr = bus_wren & ~bus_addr;
  assign flush     = status_wr & bus_wrdata[7];

  // A pop frees the slot a same-cycle push needs, so full+pop never overflows.
  assign tx_pop  = ~tx_empty & tx_ready & ~flush;
  assign tx_push = bus_wren & bus_addr & (~tx_full | tx_pop) & ~flush;
  assign tx_drop = bus_wren & bus_addr & tx_full & ~tx_pop & ~flush;

  assign rx_pop  = bus_rden & bus_addr & ~rx_empty & ~flush;
  assign rx_push = rx_valid & (~rx_full | rx_pop) & ~flush;
  assign rx_drop = rx_valid & rx_full & ~rx_pop & ~flush;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 9'h000 : tx_mem[tx_rd_ptr_reg];

  assign status_word = {28'b0, tx_ovf_reg, rx_ovf_reg, tx_full, ~rx_empty};
  assign unused_wrdata = ^{bus_wrdata[31:9], bus_wrdata[6:4], bus_wrdata[1:0]};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus_wrdata[8:0];
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
      rx_cnt_reg    <= '0;
    end else if (flush) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      tx_cnt_reg <= tx_cnt_reg + (DEPTH_LOG2 + 1)'(tx_push) - (DEPTH_LOG2 + 1)'(tx_pop);
      rx_cnt_reg <= rx_cnt_reg + (DEPTH_LOG2 + 1)'(rx_push) - (DEPTH_LOG2 + 1)'(rx_pop);
    end
  end

  // Sticky flags: a fresh overflow in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ovf_reg <= 1'b0;
      tx_ovf_reg <= 1'b0;
    end else begin
      if (rx_drop)                         rx_ovf_reg <= 1'b1;
      else if (status_wr && bus_wrdata[2]) rx_ovf_reg <= 1'b0;
      if (tx_drop)                         tx_ovf_reg <= 1'b1;
      else if (status_wr && bus_wrdata[3]) tx_ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_rddata <= '0;
    end else if (bus_rden) begin
      if (!bus_addr)     bus_rddata <= status_word;
      else if (rx_empty) bus_rddata <= '0;
      else               bus_rddata <= {24'b0, rx_mem[rx_rd_ptr_reg]};
    end
  end

endmodule

// File: tb/tb_esp_host_if.sv
// Directed bench for esp_host_if: queue-based reference model checked every
// cycle, plus literal expectations on each scripted access.
module tb_esp_host_if;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_addr = 1'b0;
  logic [31:0] bus_wrdata = '0;
  logic        bus_wren = 1'b0;
  logic        bus_rden = 1'b0;
  logic [31:0] bus_rddata;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  esp_host_if #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, outputs derived from queue contents.
  logic [8:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  bit          m_rxovf = 0, m_txovf = 0;
  logic [31:0] m_rd = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tx.delete(); m_rx.delete();
      m_rxovf = 0; m_txovf = 0; m_rd = '0;
    end else begin
      if (bus_rden) begin
        if (!bus_addr)
          m_rd = {28'b0, m_txovf, m_rxovf, m_tx.size() == 16, m_rx.size() > 0};
        else
          m_rd = (m_rx.size() > 0) ? {24'b0, m_rx[0]} : 32'h0;
      end
      if (bus_wren && !bus_addr) begin
        if (bus_wrdata[2]) m_rxovf = 0;
        if (bus_wrdata[3]) m_txovf = 0;
      end
      if (bus_wren && !bus_addr && bus_wrdata[7]) begin
        m_tx.delete(); m_rx.delete();
      end else begin
        if (bus_rden && bus_addr && m_rx.size() > 0) void'(m_rx.pop_front());
        if (rx_valid) begin
          if (m_rx.size() < 16) m_rx.push_back(rx_data);
          else m_rxovf = 1;
        end
        if (tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
        if (bus_wren && bus_addr) begin
          if (m_tx.size() < 16) m_tx.push_back(bus_wrdata[8:0]);
          else m_txovf = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_tx_valid", {31'b0, tx_valid}, {31'b0, m_tx.size() != 0});
    if (m_tx.size() != 0) check("cyc_tx_data", {23'b0, tx_data}, {23'b0, m_tx[0]});
    check("cyc_rddata", bus_rddata, m_rd);
  end

  task automatic bus_write(input logic a, input logic [31:0] d);
    bus_addr = a; bus_wrdata = d; bus_wren = 1'b1;
    @(negedge clk);
    bus_wren = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    bus_addr = a; bus_rden = 1'b1;
    @(negedge clk);
    bus_rden = 1'b0;
    d = bus_rddata;
    $display("read  addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_rddata", bus_rddata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    bus_read(1'b0, d); check("status_after_reset", d, 32'h0);
    bus_read(1'b1, d); check("data_empty", d, 32'h0);
    bus_read(1'b0, d); check("status_after_empty_read", d, 32'h0);

    // TX ordering and stall stability
    bus_write(1'b1, 32'h100);
    bus_write(1'b1, 32'h010);
    bus_write(1'b1, 32'h02F);
    check("tx_valid_stalled", {31'b0, tx_valid}, 32'h1);
    check("tx_head_stalled", {23'b0, tx_data}, 32'h100);
    repeat (2) @(negedge clk);
    check("tx_head_stable", {23'b0, tx_data}, 32'h100);
    tx_ready = 1'b1;
    check("tx_seq0", {23'b0, tx_data}, 32'h100);
    @(negedge clk); check("tx_seq1", {23'b0, tx_data}, 32'h010);
    @(negedge clk); check("tx_seq2", {23'b0, tx_data}, 32'h02F);
    @(negedge clk); tx_ready = 1'b0;
    check("tx_drained", {31'b0, tx_valid}, 32'h0);

    // RX overflow
    for (int i = 0; i < 18; i++) rx_send(8'(i));
    bus_read(1'b0, d); check("rx_ovf_status", d, 32'h5);
    for (int i = 0; i < 16; i++) begin
      bus_read(1'b1, d); check("rx_data_order", d, 32'(i));
    end
    bus_read(1'b0, d); check("rx_empty_ovf", d, 32'h4);
    bus_write(1'b0, 32'h4);
    bus_read(1'b0, d); check("rx_ovf_cleared", d, 32'h0);

    // Full RX with same-cycle push and pop
    for (int i = 0; i < 16; i++) rx_send(8'(8'h30 + i));
    rx_valid = 1'b1; rx_data = 8'hAA;
    bus_read(1'b1, d);
    rx_valid = 1'b0;
    check("full_pushpop_data", d, 32'h30);
    bus_read(1'b0, d); check("full_pushpop_status", d, 32'h1);
    for (int i = 1; i < 16; i++) begin
      bus_read(1'b1, d); check("full_pushpop_order", d, 32'(8'h30 + i));
    end
    bus_read(1'b1, d); check("full_pushpop_last", d, 32'hAA);
    bus_read(1'b0, d); check("full_pushpop_final", d, 32'h0);

    // TX overflow and flush
    for (int i = 0; i < 16; i++) bus_write(1'b1, 32'(8'h40 + i));
    bus_read(1'b0, d); check("tx_full_status", d, 32'h2);
    bus_write(1'b1, 32'h0EE);
    bus_read(1'b0, d); check("tx_ovf_status", d, 32'hA);
    bus_write(1'b0, 32'h80);
    check("flush_tx_valid", {31'b0, tx_valid}, 32'h0);
    bus_read(1'b0, d); check("flush_status", d, 32'h8);
    bus_write(1'b0, 32'h8);
    bus_read(1'b0, d); check("tx_ovf_cleared", d, 32'h0);

    // Reset mid-drain
    for (int i = 0; i < 5; i++) rx_send(8'(8'h51 + i));
    for (int i = 0; i < 3; i++) bus_write(1'b1, 32'(9'h1A0 + i));
    bus_read(1'b1, d); check("pre_reset_data", d, 32'h51);
    tx_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("midreset_tx_data", {23'b0, tx_data}, 32'h0);
    check("midreset_rddata", bus_rddata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; tx_ready = 1'b0;
    bus_read(1'b0, d); check("post_reset_status", d, 32'h0);
    bus_read(1'b1, d); check("post_reset_data", d, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
